// File: rtl/scan_pkg.sv
// ---------------------------------------------------------------------------
// scan_pkg
// Shared definitions for the truth-table scanner:
//   IDX_W  - width of the input vector {A,B,C,D}
//   TT_W   - number of truth-table entries (2**IDX_W)
//   CNT_W  - width of the minterm counter (wide enough to hold TT_W)
//   scan_state_t - scanner FSM states
// ---------------------------------------------------------------------------
package scan_pkg;

    localparam int IDX_W = 4;
    localparam int TT_W  = 16;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

endpackage

// File: rtl/settle_timer.sv
// ---------------------------------------------------------------------------
// settle_timer
// 4-bit down-counter that measures how long the scanner holds one input
// vector before sampling. While 'run' is high it asserts 'expire' on the
// HOLD_CYCLES-th consecutive run cycle, then returns to zero ready for the
// next vector.
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (count -> 0)
//   clear   in   force the count to zero (start of a scan)
//   run     in   high during each hold cycle
//   expire  out  combinational: this run cycle is the last hold cycle
//
// HOLD_CYCLES legal range is 1..15.
// ---------------------------------------------------------------------------
module settle_timer #(
    parameter int unsigned HOLD_CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic expire
);

    localparam logic [3:0] HOLD    = 4'(HOLD_CYCLES);
    localparam logic [3:0] HOLD_M1 = 4'(HOLD_CYCLES - 1);

    logic [3:0] count_reg;
    logic [3:0] count_next;

    // A count of zero means "first cycle of a hold": the counter is loaded
    // there, so the zero state needs no extra arming flag. A one-cycle hold
    // expires directly from zero.
    always_comb begin
        expire     = run && (((count_reg == 4'd0) && (HOLD == 4'd1)) ||
                             (count_reg == 4'd1));
        count_next = count_reg;
        if (clear) begin
            count_next = 4'd0;
        end else if (run) begin
            if (expire) begin
                count_next = 4'd0;
            end else if (count_reg == 4'd0) begin
                count_next = HOLD_M1;
            end else begin
                count_next = count_reg - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 4'd0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
// Walks the 4-bit input vector abcd = {A,B,C,D} through 0..15, holds each
// value for SETTLE_CYCLES cycles so the external function mux can settle,
// then samples y_in into table_q[abcd]. One scan per accepted start.
//
// Ports:
//   clk       in   clock, all state changes on the rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   scan request (level, only looked at in IDLE)
//   y_in      in   function value returned by the external mux
//   abcd      out  current input vector, A is the MSB
//   busy      out  high in DRIVE and SAMPLE
//   done      out  one-cycle pulse in DONE
//   table_q   out  captured truth table, bit i = F(abcd=i)
//   ones_cnt  out  number of ones captured (0..16)
//
// Build option: define SCAN_MINTERM_COUNT_EN to include the minterm counter;
// without it ones_cnt is a constant zero.
// ---------------------------------------------------------------------------
module truth_table_scanner
    import scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             y_in,
    output logic [IDX_W-1:0] abcd,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  table_q,
    output logic [CNT_W-1:0] ones_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    scan_state_t      state_reg, state_next;
    logic [IDX_W-1:0] abcd_reg, abcd_next;
    logic [TT_W-1:0]  table_reg, table_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;
    logic             timer_clear;
    logic             timer_run;
    logic             timer_expire;

    settle_timer #(
        .HOLD_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .run    (timer_run),
        .expire (timer_expire)
    );

    // Next-state and next-output logic. busy/done are derived from the
    // next state so that they are registered and line up with the state.
    always_comb begin
        state_next  = state_reg;
        abcd_next   = abcd_reg;
        table_next  = table_reg;
        timer_clear = 1'b0;
        timer_run   = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next  = DRIVE;
                    abcd_next   = '0;
                    table_next  = '0;
                    timer_clear = 1'b1;
                end
            end
            DRIVE: begin
                timer_run = 1'b1;
                if (timer_expire) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                table_next[abcd_reg] = y_in;
                if (abcd_reg == LAST_IDX) begin
                    // abcd stays at the last vector; no wrap to zero
                    state_next = DONE;
                end else begin
                    abcd_next  = abcd_reg + 1'b1;
                    state_next = DRIVE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next == DRIVE) || (state_next == SAMPLE);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            abcd_reg  <= '0;
            table_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            abcd_reg  <= abcd_next;
            table_reg <= table_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

`ifdef SCAN_MINTERM_COUNT_EN
    logic [CNT_W-1:0] ones_reg, ones_next;

    always_comb begin
        ones_next = ones_reg;
        if ((state_reg == IDLE) && start) begin
            ones_next = '0;
        end else if (state_reg == SAMPLE) begin
            ones_next = ones_reg + CNT_W'(y_in);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_reg <= '0;
        end else begin
            ones_reg <= ones_next;
        end
    end

    assign ones_cnt = ones_reg;
`else
    assign ones_cnt = '0;
`endif

    assign abcd    = abcd_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign table_q = table_reg;

endmodule

// File: tb/tb_truth_table_scanner.sv
// ---------------------------------------------------------------------------
// tb_truth_table_scanner
// Drives two scanner instances (SETTLE_CYCLES = 1 and 3). The external
// function mux is modelled here; y_in is either the 8:1 mux function or a
// lookup into a chosen 16-bit pattern. Expected results are queued when a
// scan is started and compared when done is observed.
// ---------------------------------------------------------------------------
module tb_truth_table_scanner;
    import scan_pkg::*;

    localparam int S1 = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             start, y_in;
    logic [IDX_W-1:0] abcd;
    logic             busy, done;
    logic [TT_W-1:0]  table_q;
    logic [CNT_W-1:0] ones_cnt;

    logic             start3, y3;
    logic [IDX_W-1:0] abcd3;
    logic             busy3, done3;
    logic [TT_W-1:0]  table3;
    logic [CNT_W-1:0] ones3;

    int          mode;     // 0: 8:1 function mux, 1: pattern lookup
    logic [15:0] pat;
    logic [15:0] pat3;

    truth_table_scanner #(.SETTLE_CYCLES(S1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .y_in(y_in),
        .abcd(abcd), .busy(busy), .done(done),
        .table_q(table_q), .ones_cnt(ones_cnt)
    );

    truth_table_scanner #(.SETTLE_CYCLES(S3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .y_in(y3),
        .abcd(abcd3), .busy(busy3), .done(done3),
        .table_q(table3), .ones_cnt(ones3)
    );

    // External mux: select = {B,C,D}, inputs I0..I7 = 1,1,~A,A,0,1,1,A
    function automatic logic mux_y(input logic [3:0] v);
        logic a;
        logic r;
        a = v[3];
        case (v[2:0])
            3'd0: r = 1'b1;
            3'd1: r = 1'b1;
            3'd2: r = ~a;
            3'd3: r = a;
            3'd4: r = 1'b0;
            3'd5: r = 1'b1;
            3'd6: r = 1'b1;
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb y_in = (mode == 0) ? mux_y(abcd) : pat[abcd];
    always_comb y3   = pat3[abcd3];

    int tests = 0;
    int fails = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if ((busy && done) || (busy3 && done3)) overlap++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic int exp_cnt(input int n);
`ifdef SCAN_MINTERM_COUNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    function automatic logic [3:0] exp_abcd(input int c, input int s);
        int v;
        v = (c - 1) / (s + 1);
        if (v > 15) v = 15;
        return 4'(v);
    endfunction

    typedef struct {
        logic [15:0] tab;
        int          ones;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        int          mode;
        logic [15:0] pat;
        logic [15:0] exp_tab;
        int          exp_ones;
        string       nm;
    } vec_t;
    vec_t vecs[6];

    // One full scan on the SETTLE_CYCLES=1 instance. Optionally pulses start
    // again after edge pulse_cyc (must be ignored mid-scan).
    task automatic run_scan(input string nm, input int pulse_cyc,
                            input logic [15:0] etab, input int eones);
        int   cyc;
        int   bad;
        bit   seen;
        exp_t e;
        e.tab  = etab;
        e.ones = eones;
        @(negedge clk);
        start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start = 1'b0;
        bad   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 400) begin
            if (abcd !== exp_abcd(cyc, S1)) bad++;
            if (busy !== (cyc <= (S1 + 1) * 16)) bad++;
            if (done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                cyc++;
                @(negedge clk);
                start = (cyc == pulse_cyc);
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check({nm, "_seq"}, 32'(bad), 32'd0);
        check({nm, "_done_cycle"}, 32'(cyc), 32'((S1 + 1) * 16 + 1));
        check({nm, "_table"}, 32'(table_q), 32'(e.tab));
        check({nm, "_ones"}, 32'(ones_cnt), 32'(e.ones));
        $display("[TB] scan %s table=%h ones=%0d done_cycle=%0d", nm, table_q, ones_cnt, cyc);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check({nm, "_after_done"}, {29'd0, done, busy, 1'b0}, 32'd0);
        end
        check({nm, "_abcd_held"}, 32'(abcd), 32'd15);
        check({nm, "_table_held"}, 32'(table_q), 32'(e.tab));
    endtask

    initial begin
        int cyc;
        int dn;
        int bad;

        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 1;
        pat    = 16'h0000;
        pat3   = 16'(($urandom() & 32'h0000FFFF) | 32'h0000_0100);

        repeat (2) @(negedge clk);
        check("reset_outputs", {13'd0, abcd, busy, done, ones_cnt, 8'd0}, 32'd0);
        check("reset_table", 32'(table_q), 32'd0);
        check("reset_outputs3", {13'd0, abcd3, busy3, done3, ones3, 8'd0}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_start", {30'd0, busy, done}, 32'd0);

        vecs[0] = '{0, 16'h0000, 16'hEB67, 11, "mux"};
        vecs[1] = '{1, 16'hFFFF, 16'hFFFF, 16, "all_ones"};
        vecs[2] = '{1, 16'h0000, 16'h0000, 0, "all_zeros"};
        vecs[3] = '{1, 16'h8001, 16'h8001, 2, "ends"};
        vecs[4] = '{1, 16'hA5C3, 16'hA5C3, 8, "a5c3"};
        vecs[5].mode = 1;
        vecs[5].pat  = 16'($urandom());
        vecs[5].exp_tab  = vecs[5].pat;
        vecs[5].exp_ones = $countones(vecs[5].pat);
        vecs[5].nm   = "random";

        for (int i = 0; i < 6; i++) begin
            mode = vecs[i].mode;
            pat  = vecs[i].pat;
            run_scan(vecs[i].nm, 0, vecs[i].exp_tab, exp_cnt(vecs[i].exp_ones));
        end

        // start pulsed mid-scan is ignored
        mode = 0;
        run_scan("mid_start", 10, 16'hEB67, exp_cnt(11));

        // start held high: back-to-back scans separated by one IDLE cycle
        mode = 1;
        pat  = 16'h1234;
        @(negedge clk);
        start = 1'b1;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("b2b_first_done", 32'(cyc), 32'd33);
        check("b2b_first_table", 32'(table_q), 32'h1234);
        pat = 16'h5A5A;
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle_gap", {30'd0, busy, done}, 32'd0);
        check("b2b_idle_hold", 32'(table_q), 32'h1234);
        @(posedge clk);
        @(negedge clk);
        check("b2b_second_start", {14'd0, busy, abcd, table_q[12:0]}, {14'd0, 1'b1, 4'd0, 13'd0});
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("b2b_second_done", 32'(cyc), 32'd32);
        check("b2b_second_table", 32'(table_q), 32'h5A5A);
        $display("[TB] scan b2b table=%h ones=%0d", table_q, ones_cnt);

        // asynchronous reset mid-scan
        mode = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {13'd0, abcd, busy, done, ones_cnt, 8'd0}, 32'd0);
        check("async_reset_table", 32'(table_q), 32'd0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (done || busy) dn++;
        end
        check("reset_abort_quiet", 32'(dn), 32'd0);
        $display("[TB] reset mid-scan, quiet cycles checked");
        run_scan("after_reset", 0, 16'hEB67, exp_cnt(11));

        // SETTLE_CYCLES = 3 instance
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        cyc = 1;
        @(negedge clk);
        start3 = 1'b0;
        bad = 0;
        while (!done3 && cyc < 200) begin
            if (abcd3 !== exp_abcd(cyc, S3)) bad++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        check("s3_seq", 32'(bad), 32'd0);
        check("s3_done_cycle", 32'(cyc), 32'((S3 + 1) * 16 + 1));
        check("s3_table", 32'(table3), 32'(pat3));
        check("s3_ones", 32'(ones3), 32'(exp_cnt($countones(pat3))));
        $display("[TB] scan s3 table=%h ones=%0d done_cycle=%0d", table3, ones3, cyc);

        check("busy_done_exclusive", 32'(overlap), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
